// File: rtl/fsic_clock_phase_recover_pkg.sv
// fsic_clk_pkg: shared types/constants for the divided-clock phase recovery.
// Holds the lock FSM state enum, watchdog width helper and error counter width.
package fsic_clk_pkg;

  localparam int ERR_CNT_W = 8;

  typedef enum logic [1:0] {
    ST_UNLOCK = 2'd0,
    ST_ACQ    = 2'd1,
    ST_LOCKED = 2'd2
  } state_e;

  function automatic int wd_width(input int ratio);
    return $clog2(2 * ratio) + 1;
  endfunction

endpackage

// File: rtl/fsic_clock_phase_recover_if.sv
// Bundle between the divided-clock source side and the phase recoverer.
// master: drives div_clk_in/clear_err; slave: returns phase/strobe/lock/errors.
interface fsic_clock_phase_recover_if
  import fsic_clk_pkg::*;
#(
  parameter int RATIO = 4
) ();

  localparam int PW = $clog2(RATIO);

  logic                 div_clk_in;
  logic                 clear_err;
  logic [PW-1:0]        phase;
  logic                 rise_strobe;
  logic                 locked;
  logic [ERR_CNT_W-1:0] err_cnt;

  modport master (
    output div_clk_in,
    output clear_err,
    input  phase,
    input  rise_strobe,
    input  locked,
    input  err_cnt
  );

  modport slave (
    input  div_clk_in,
    input  clear_err,
    output phase,
    output rise_strobe,
    output locked,
    output err_cnt
  );

endinterface

// File: rtl/fsic_clock_phase_recover_edge_det.sv
// Two-flop sampler of the divided clock on in_clk; emits rise/fall pulses.
// Ports: in_clk, resetb (async low), i_d sample in, o_rise/o_fall combinational.
module fsic_clk_edge_det (
  input  logic in_clk,
  input  logic resetb,
  input  logic i_d,
  output logic o_rise,
  output logic o_fall
);

  logic r_q;
  logic r_q2;

  always_ff @(posedge in_clk or negedge resetb) begin
    if (!resetb) begin
      r_q  <= 1'b0;
      r_q2 <= 1'b0;
    end else begin
      r_q  <= i_d;
      r_q2 <= r_q;
    end
  end

  assign o_rise = r_q & ~r_q2;
  assign o_fall = ~r_q & r_q2;

endmodule

// File: rtl/fsic_clock_phase_recover.sv
// Recovers divide-by-RATIO phase, checks period/duty, tracks lock and errors.
// Ports: in_clk, resetb (async low), bus (slave: div_clk_in/clear_err in; phase/rise_strobe/locked/err_cnt out).
module fsic_clock_phase_recover
  import fsic_clk_pkg::*;
#(
  parameter int RATIO    = 4,
  parameter int LOCK_CNT = 8,
  parameter int ERR_MAX  = 3
) (
  input logic                         in_clk,
  input logic                         resetb,
  fsic_clock_phase_recover_if.slave   bus
);

  localparam int PW = $clog2(RATIO);
  localparam int WW = wd_width(RATIO);

  localparam logic [PW-1:0] P_LAST  = PW'(RATIO - 1);
  localparam logic [PW-1:0] P_HALF  = PW'(RATIO / 2 - 1);
  localparam logic [WW-1:0] WD_LAST = WW'(2 * RATIO - 1);
  localparam logic [7:0]    G_LAST  = 8'(LOCK_CNT - 1);
  localparam logic [3:0]    M_LAST  = 4'(ERR_MAX - 1);

  logic                 w_rise;
  logic                 w_fall;
  logic                 w_wd_fire;
  logic                 w_judge;
  logic                 w_good_p;
  logic                 w_bad;

  logic [PW-1:0]        r_pcnt;
  logic [WW-1:0]        r_wd;
  logic                 r_fall_ok;
  state_e               r_state;
  logic [7:0]           r_good;
  logic [3:0]           r_miss;
  logic [ERR_CNT_W-1:0] r_err;
  logic                 r_strobe;
  logic                 r_locked;

  state_e               w_state_nxt;
  logic [7:0]           w_good_nxt;
  logic [3:0]           w_miss_nxt;
  logic [ERR_CNT_W-1:0] w_err_nxt;

  fsic_clk_edge_det u_edge (
    .in_clk (in_clk),
    .resetb (resetb),
    .i_d    (bus.div_clk_in),
    .o_rise (w_rise),
    .o_fall (w_fall)
  );

  // A rise is the watchdog's own reload, so it never fires on a rise.
  assign w_wd_fire = ~w_rise & (r_wd == WD_LAST);
  assign w_judge   = (r_state != ST_UNLOCK);

  assign w_good_p = w_rise & (r_pcnt == P_LAST)
                  & r_fall_ok;

  // Rise with wrong fall but right period is neither good
  // nor bad: the fall already reported that period.
  assign w_bad = w_judge & (
      (w_rise & (r_pcnt != P_LAST))
    | (w_fall & (r_pcnt != P_HALF))
    | w_wd_fire);

  always_comb begin
    w_state_nxt = r_state;
    w_good_nxt  = r_good;
    w_miss_nxt  = r_miss;
    w_err_nxt   = r_err;
    unique case (r_state)
      ST_UNLOCK: begin
        if (w_rise) begin
          w_state_nxt = ST_ACQ;
          w_good_nxt  = '0;
        end
      end
      ST_ACQ: begin
        if (w_bad) begin
          w_good_nxt = '0;
        end else if (w_good_p) begin
          w_good_nxt = r_good + 8'd1;
          if (r_good == G_LAST) begin
            w_state_nxt = ST_LOCKED;
            w_miss_nxt  = '0;
          end
        end
      end
      ST_LOCKED: begin
        if (w_bad) begin
          if (r_err != '1) w_err_nxt = r_err + 1'b1;
          w_miss_nxt = r_miss + 4'd1;
          if (r_miss == M_LAST) begin
            w_state_nxt = ST_ACQ;
            w_good_nxt  = '0;
          end
        end else if (w_good_p) begin
          w_miss_nxt = '0;
        end
      end
      default: begin
        w_state_nxt = ST_UNLOCK;
      end
    endcase
    if (bus.clear_err) w_err_nxt = '0;
  end

  always_ff @(posedge in_clk or negedge resetb) begin
    if (!resetb) begin
      r_state <= ST_UNLOCK;
      r_good  <= '0;
      r_miss  <= '0;
      r_err   <= '0;
      r_locked <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_good  <= w_good_nxt;
      r_miss  <= w_miss_nxt;
      r_err   <= w_err_nxt;
      r_locked <= (w_state_nxt == ST_LOCKED);
    end
  end

  always_ff @(posedge in_clk or negedge resetb) begin
    if (!resetb) begin
      r_pcnt    <= '0;
      r_wd      <= '0;
      r_fall_ok <= 1'b0;
      r_strobe  <= 1'b0;
    end else begin
      r_pcnt   <= w_rise ? '0 : r_pcnt + 1'b1;
      r_wd     <= (w_rise | w_wd_fire) ? '0
                : r_wd + 1'b1;
      r_strobe <= w_rise;
      if (w_fall) r_fall_ok <= (r_pcnt == P_HALF);
    end
  end

  assign bus.phase       = r_pcnt;
  assign bus.rise_strobe = r_strobe;
  assign bus.locked      = r_locked;
  assign bus.err_cnt     = r_err;

endmodule
